// File: rtl/filter_frame_ctrl_if.sv
// Bundle of control, source-pixel, filter-output and status signals between
// the frame sequencer and the rest of the filter pipeline.
interface filter_frame_ctrl_if #(
  parameter int KSEL_W = 3
);
  logic              start_in;
  logic              abort_in;
  logic [KSEL_W-1:0] kernel_sel_in;
  logic              data_valid_in;
  logic [10:0]       hcount_in;
  logic [9:0]        vcount_in;
  logic              filt_valid_in;
  logic [10:0]       filt_hcount_in;
  logic [9:0]        filt_vcount_in;
  logic              filter_valid_out;
  logic [KSEL_W-1:0] kernel_sel_out;
  logic              busy_out;
  logic              done_out;
  logic              timeout_out;
  logic [16:0]       in_count_out;
  logic [16:0]       out_count_out;

  modport slave (
    input  start_in, abort_in, kernel_sel_in, data_valid_in, hcount_in, vcount_in,
           filt_valid_in, filt_hcount_in, filt_vcount_in,
    output filter_valid_out, kernel_sel_out, busy_out, done_out, timeout_out,
           in_count_out, out_count_out
  );

  modport master (
    output start_in, abort_in, kernel_sel_in, data_valid_in, hcount_in, vcount_in,
           filt_valid_in, filt_hcount_in, filt_vcount_in,
    input  filter_valid_out, kernel_sel_out, busy_out, done_out, timeout_out,
           in_count_out, out_count_out
  );
endinterface

// File: rtl/filter_frame_ctrl.sv
// Frame sequencer: gates exactly one camera frame into the convolution filter,
// holds the kernel select for that frame and reports done/timeout plus pixel counts.
module filter_frame_ctrl #(
  parameter int H_ACTIVE      = 320,
  parameter int V_ACTIVE      = 180,
  parameter int KSEL_W        = 3,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  filter_frame_ctrl_if.slave  bus
);
  localparam int CNT_W = 17;
  localparam int TMR_W = $clog2(DRAIN_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_reg, state_next;
  logic [KSEL_W-1:0] ksel_reg;
  logic [CNT_W-1:0]  in_cnt_reg;
  logic [CNT_W-1:0]  out_cnt_reg;
  logic [TMR_W-1:0]  timer_reg;
  logic              timeout_reg;

  logic in_range, first_pix, gate, src_last, filt_last, tmr_hit, start_ok, armed;

  assign in_range  = (bus.hcount_in < 11'(H_ACTIVE)) && (bus.vcount_in < 10'(V_ACTIVE));
  assign first_pix = bus.data_valid_in && (bus.hcount_in == 11'd0) && (bus.vcount_in == 10'd0);
  // Gate depends only on state and live inputs, so an async reset closes it immediately.
  assign gate      = bus.data_valid_in && in_range &&
                     ((state_reg == S_RUN) || ((state_reg == S_ARM) && first_pix));
  assign src_last  = gate && (bus.hcount_in == 11'(H_ACTIVE - 1)) &&
                     (bus.vcount_in == 10'(V_ACTIVE - 1));
  assign filt_last = bus.filt_valid_in && (bus.filt_hcount_in == 11'(H_ACTIVE - 1)) &&
                     (bus.filt_vcount_in == 10'(V_ACTIVE - 1));
  assign tmr_hit   = (timer_reg == TMR_W'(DRAIN_TIMEOUT - 1));
  assign start_ok  = (state_reg == S_IDLE) && bus.start_in && !bus.abort_in;
  assign armed     = (state_reg == S_ARM) || (state_reg == S_RUN) || (state_reg == S_DRAIN);

  always_comb begin
    state_next = state_reg;
    if (bus.abort_in) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:  if (bus.start_in) state_next = S_ARM;
        S_ARM:   if (gate) state_next = src_last ? S_DRAIN : S_RUN;
        S_RUN:   if (src_last) state_next = S_DRAIN;
        S_DRAIN: if (filt_last || tmr_hit) state_next = S_DONE;
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg   <= S_IDLE;
      ksel_reg    <= '0;
      in_cnt_reg  <= '0;
      out_cnt_reg <= '0;
      timer_reg   <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= (state_reg == S_DRAIN) ? timer_reg + 1'b1 : '0;
      if (start_ok) begin
        ksel_reg    <= bus.kernel_sel_in;
        in_cnt_reg  <= '0;
        out_cnt_reg <= '0;
        timeout_reg <= 1'b0;
      end else begin
        if (gate && (in_cnt_reg != CNT_MAX))
          in_cnt_reg <= in_cnt_reg + 1'b1;
        if (bus.filt_valid_in && armed && (out_cnt_reg != CNT_MAX))
          out_cnt_reg <= out_cnt_reg + 1'b1;
        // A real last output in the same cycle as expiry counts as normal completion.
        if ((state_reg == S_DRAIN) && tmr_hit && !filt_last && !bus.abort_in)
          timeout_reg <= 1'b1;
      end
    end
  end

  assign bus.filter_valid_out = gate;
  assign bus.kernel_sel_out   = ksel_reg;
  assign bus.busy_out         = armed;
  assign bus.done_out         = (state_reg == S_DONE);
  assign bus.timeout_out      = timeout_reg;
  assign bus.in_count_out     = in_cnt_reg;
  assign bus.out_count_out    = out_cnt_reg;
endmodule
